// File: rtl/tracker_pkg.sv
// Shared definitions for the pulse-tracker sequencing blocks: state encoding,
// channel count, stream word layout and field widths.
package tracker_pkg;

  localparam int SENSOR_NB = 8;
  localparam int IDX_W     = $clog2(SENSOR_NB);
  localparam int ITER_W    = 17;
  localparam int POLY_W    = 17;

  // Stream word: [39:37] sensor index, [36:20] polynomial, [19:17] zero, [16:0] iteration.
  localparam int DATA_W    = 40;
  localparam int IDX_LSB   = 37;
  localparam int POLY_LSB  = 20;
  localparam int ITER_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

  function automatic logic [DATA_W-1:0] pack_word(
    input logic [IDX_W-1:0]  idx,
    input logic [POLY_W-1:0] poly,
    input logic [ITER_W-1:0] iter
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[IDX_LSB +: IDX_W]   = idx;
    w[POLY_LSB +: POLY_W] = poly;
    w[ITER_LSB +: ITER_W] = iter;
    return w;
  endfunction

  // True when no mask bit strictly above idx is set, i.e. idx is the final word.
  function automatic logic none_above(
    input logic [SENSOR_NB-1:0] mask,
    input logic [IDX_W-1:0]     idx
  );
    logic [SENSOR_NB-1:0] m;
    m = mask >> idx;
    return (m[SENSOR_NB-1:1] == '0);
  endfunction

endpackage

// File: rtl/next_set_bit.sv
// Finds the lowest set mask bit at or above start_i; start_i may equal
// SENSOR_NB, in which case nothing is found.
module next_set_bit
  import tracker_pkg::*;
(
  input  logic [SENSOR_NB-1:0] mask_i,
  input  logic [IDX_W:0]       start_i,
  output logic [IDX_W-1:0]     index_o,
  output logic                 found_o
);

  logic [SENSOR_NB-1:0] cand;

  genvar gi;
  for (gi = 0; gi < SENSOR_NB; gi++) begin : g_cand
    assign cand[gi] = mask_i[gi] && (start_i <= (IDX_W+1)'(gi));
  end

  // Scanning downward leaves the lowest candidate as the final assignment.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = SENSOR_NB - 1; i >= 0; i--) begin
      if (cand[i]) begin
        index_o = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sweep_result_scheduler.sv
// Waits for a pulse_identifier result under a watchdog, streams the non-zero
// per-sensor iterations with the polynomial, then pulses the identifier reset.
module sweep_result_scheduler
  import tracker_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 72000,
  parameter int SENSOR_NB     = tracker_pkg::SENSOR_NB
) (
  input  logic                        clk_72MHz,
  input  logic                        reset,
  input  logic                        sweep_active,
  input  logic                        id_ready,
  input  logic [POLY_W-1:0]           id_polynomial,
  input  logic [SENSOR_NB*ITER_W-1:0] id_iterations,
  output logic                        id_reset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic [15:0]                 sweep_count,
  output logic [7:0]                  timeout_count
);

  localparam int WD_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_TICKS - 1);

  state_e state_q, state_d;
  logic [WD_W-1:0]                  wd_q, wd_d;
  logic [SENSOR_NB-1:0]             mask_q, mask_d;
  logic [POLY_W-1:0]                poly_q, poly_d;
  logic [SENSOR_NB-1:0][ITER_W-1:0] iters_q, iters_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             out_valid_q, out_valid_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic                             out_last_q, out_last_d;
  logic                             id_reset_q, id_reset_d;
  logic                             busy_q, busy_d;
  logic [15:0]                      sweep_count_q, sweep_count_d;
  logic [7:0]                       timeout_count_q, timeout_count_d;

  logic [SENSOR_NB-1:0][ITER_W-1:0] iter_now;
  logic [SENSOR_NB-1:0]             mask_now;
  logic [SENSOR_NB-1:0]             nsb_mask;
  logic [IDX_W:0]                   nsb_start;
  logic [IDX_W-1:0]                 nsb_index;
  logic                             nsb_found;

  assign iter_now = id_iterations;

  genvar gi;
  for (gi = 0; gi < SENSOR_NB; gi++) begin : g_mask
    assign mask_now[gi] = (iter_now[gi] != '0);
  end

  // One search unit: seeded from the live result in CAPTURE, from the latched mask in EMIT.
  next_set_bit u_next_set_bit (
    .mask_i  (nsb_mask),
    .start_i (nsb_start),
    .index_o (nsb_index),
    .found_o (nsb_found)
  );

  always_comb begin
    state_d         = state_q;
    wd_d            = wd_q;
    mask_d          = mask_q;
    poly_d          = poly_q;
    iters_d         = iters_q;
    idx_d           = idx_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_last_d      = out_last_q;
    id_reset_d      = id_reset_q;
    sweep_count_d   = sweep_count_q;
    timeout_count_d = timeout_count_q;
    nsb_mask        = mask_q;
    nsb_start       = {1'b0, idx_q} + (IDX_W+1)'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (id_ready) begin
          state_d = ST_CAPTURE;
        end else if (sweep_active) begin
          state_d = ST_ARMED;
          wd_d    = '0;
        end
      end

      ST_ARMED: begin
        if (id_ready) begin
          state_d = ST_CAPTURE;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_DRAIN;
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_CAPTURE: begin
        nsb_mask      = mask_now;
        nsb_start     = '0;
        mask_d        = mask_now;
        poly_d        = id_polynomial;
        iters_d       = iter_now;
        sweep_count_d = sweep_count_q + 16'd1;
        if (!nsb_found) begin
          state_d    = ST_RELEASE;
          id_reset_d = 1'b1;
          wd_d       = '0;
        end else begin
          // First word is built from the live inputs so it is valid on the very next cycle.
          state_d     = ST_EMIT;
          idx_d       = nsb_index;
          out_valid_d = 1'b1;
          out_data_d  = pack_word(nsb_index, id_polynomial, iter_now[nsb_index]);
          out_last_d  = none_above(mask_now, nsb_index);
        end
      end

      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = ST_RELEASE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            id_reset_d  = 1'b1;
            wd_d        = '0;
          end else begin
            idx_d      = nsb_index;
            out_data_d = pack_word(nsb_index, poly_q, iters_q[nsb_index]);
            out_last_d = none_above(mask_q, nsb_index);
          end
        end
      end

      ST_RELEASE: begin
        if (!id_ready) begin
          state_d    = ST_DRAIN;
          id_reset_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d    = ST_DRAIN;
          id_reset_d = 1'b0;
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_DRAIN: begin
        if (!sweep_active) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wd_q            <= '0;
      mask_q          <= '0;
      poly_q          <= '0;
      iters_q         <= '0;
      idx_q           <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      id_reset_q      <= 1'b0;
      busy_q          <= 1'b0;
      sweep_count_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      mask_q          <= mask_d;
      poly_q          <= poly_d;
      iters_q         <= iters_d;
      idx_q           <= idx_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      id_reset_q      <= id_reset_d;
      busy_q          <= busy_d;
      sweep_count_q   <= sweep_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign id_reset      = id_reset_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign sweep_count   = sweep_count_q;
  assign timeout_count = timeout_count_q;

endmodule
